// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// uart_rx_param: parametrised UART receiver.
// Oversamples the asynchronous RX pin with an internal baud counter, rejects
// false starts, checks parity and stop bits, and holds each received word on
// a valid/ready handshake with overrun detection.
//
// Handshake: rx_valid rises on the edge that commits a frame and stays high
// until a cycle where rx_valid & rx_ready, clearing on the next edge.
// data_out and the error flags change only on a commit, so they are stable
// while rx_valid is high. A commit in the same cycle as an acceptance wins:
// rx_valid stays high with the new word and no overrun is flagged.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 system_clk,
  input  logic                 rst_n,
  input  logic                 rx_data,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy,
  output logic [2:0]           flag_state
);

  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP  = (STOP_BITS == 2);
  localparam logic          HAS_PARITY = (PARITY != 0);
  localparam logic          ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   sync_1;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   sr;
  logic                   armed;
  logic                   perr_acc;
  logic                   ferr_acc;

  // Strobes decoded from the FSM for the datapath.
  logic                   cnt_clr;
  logic                   go_start;
  logic                   shift_en;
  logic                   par_en;
  logic                   stop_en;
  logic                   commit;
  logic                   par_calc;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx_data;
      rx_s   <= sync_1;
    end
  end

  // FSM state register.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and sampling strobes; every sample also clears cnt.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    go_start   = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        // Only a high-to-low transition seen from IDLE starts a frame, so a
        // held-low line after a break does not retrigger.
        if (!rx_s && armed) begin
          state_next = S_START;
          go_start   = 1'b1;
        end
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) state_next = HAS_PARITY ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt == CNT_FULL) begin
          cnt_clr    = 1'b1;
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_clr = 1'b1;
          stop_en = 1'b1;
          if (stop_idx == LAST_STOP) begin
            commit     = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        cnt_clr    = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  // Baud counter: free-runs inside a bit period, cleared on entry and sample.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  // Data bit and stop bit indices for the current frame.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (state == S_IDLE) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (shift_en) bit_idx  <= bit_idx + 4'd1;
      if (stop_en)  stop_idx <= 1'b1;
    end
  end

  // Start-edge arming: set while idling on a high line, dropped on START.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n)                        armed <= 1'b0;
    else if (state == S_IDLE && rx_s)  armed <= 1'b1;
    else if (go_start)                 armed <= 1'b0;
  end

  // Receive shift register: LSB arrives first, so shift in at the MSB.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n)        sr <= '0;
    else if (shift_en) sr <= {rx_s, sr[DATA_BITS-1:1]};
  end

  // XOR of the complete data word with the received parity bit.
  assign par_calc = (^sr) ^ rx_s;

  // Per-frame parity and framing error accumulators.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (go_start) begin
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (par_en)           perr_acc <= ODD_PARITY ? ~par_calc : par_calc;
      if (stop_en && !rx_s) ferr_acc <= 1'b1;
    end
  end

  // Output holding register with the valid/ready handshake and overrun pulse.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (commit) begin
      data_out    <= sr;
      parity_err  <= HAS_PARITY & perr_acc;
      frame_err   <= ferr_acc | ~rx_s;
      rx_valid    <= 1'b1;
      overrun_err <= rx_valid & ~rx_ready;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
  end

  assign busy       = (state != S_IDLE);
  assign flag_state = state;

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Bench for uart_rx_param: three instances (8N1, 8E1, 7O2) at 16 clocks/bit,
// table-driven frames, hand-written corner sequences and random frames
// checked against a frame-level reference model.
module tb_uart_rx_param;

  localparam int C = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rdy;
  logic       rx_line [3];
  logic [8:0] dout    [3];
  logic [2:0] fst     [3];
  logic [2:0] vld, perr, ferr, ovr, busy;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DB = (g == 2) ? 7 : 8;
    localparam int PM = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    localparam int SB = (g == 2) ? 2 : 1;
    logic [DB-1:0] d;
    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .PARITY(PM), .STOP_BITS(SB)) u_dut (
      .system_clk (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_line[g]),
      .rx_ready   (rdy),
      .data_out   (d),
      .rx_valid   (vld[g]),
      .parity_err (perr[g]),
      .frame_err  (ferr[g]),
      .overrun_err(ovr[g]),
      .busy       (busy[g]),
      .flag_state (fst[g])
    );
    assign dout[g] = 9'(d);
  end

  // ---------------- configuration helpers ----------------
  function automatic int db_of(input int id);
    return (id == 2) ? 7 : 8;
  endfunction
  function automatic int pm_of(input int id);
    return (id == 0) ? 0 : ((id == 1) ? 2 : 1);
  endfunction
  function automatic int sb_of(input int id);
    return (id == 2) ? 2 : 1;
  endfunction
  function automatic int exp_lat(input int id);
    return C / 2 + (db_of(id) + ((pm_of(id) != 0) ? 1 : 0) + sb_of(id)) * C;
  endfunction

  // ---------------- monitor ----------------
  typedef struct {
    int         id;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         lat;
  } obs_t;

  obs_t       obs_q [$];
  int         cyc;
  int         start_cyc [3];
  int         start_cnt [3];
  int         ovr_cnt   [3];
  int         hold_viol;
  logic       pv    [3];
  logic [8:0] pd    [3];
  logic       ppe   [3];
  logic       pfe   [3];
  logic [2:0] pfst  [3];
  logic       prdy;

  always @(negedge clk) begin
    obs_t o;
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        pv[g]   = 1'b0;
        pfst[g] = 3'd0;
      end else begin
        if (fst[g] == 3'd1 && pfst[g] != 3'd1) begin
          start_cyc[g] = cyc;
          start_cnt[g]++;
        end
        if (ovr[g]) ovr_cnt[g]++;
        if (vld[g] && (!pv[g] || prdy || ovr[g])) begin
          o.id   = g;
          o.data = dout[g];
          o.perr = perr[g];
          o.ferr = ferr[g];
          o.lat  = cyc - start_cyc[g];
          obs_q.push_back(o);
        end else if (pv[g] && !prdy &&
                     (!vld[g] || dout[g] !== pd[g] || perr[g] !== ppe[g] || ferr[g] !== pfe[g])) begin
          hold_viol++;
        end
        pv[g]   = vld[g];
        pd[g]   = dout[g];
        ppe[g]  = perr[g];
        pfe[g]  = ferr[g];
        pfst[g] = fst[g];
      end
    end
    prdy = rdy;
  end

  // ---------------- scoreboard helpers ----------------
  int n_cmp;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int id, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input int gap);
    rx_line[id] = 1'b0;
    tick(C);
    for (int i = 0; i < db_of(id); i++) begin
      rx_line[id] = data[i];
      tick(C);
    end
    if (pm_of(id) != 0) begin
      rx_line[id] = pbit;
      tick(C);
    end
    for (int s = 0; s < sb_of(id); s++) begin
      rx_line[id] = stops[s];
      tick(C);
    end
    rx_line[id] = 1'b1;
    tick(gap);
  endtask

  task automatic expect_word(input int id, input logic [8:0] e_data, input logic e_perr,
                             input logic e_ferr, input string nm);
    obs_t o;
    int   waited;
    waited = 0;
    while (obs_q.size() == 0 && waited < 400) begin
      tick(1);
      waited++;
    end
    if (obs_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no word expected one word", nm);
    end else begin
      o = obs_q.pop_front();
      chk({nm, "_id"},   32'(o.id),   32'(id));
      chk({nm, "_data"}, 32'(o.data), 32'(e_data));
      chk({nm, "_perr"}, 32'(o.perr), 32'(e_perr));
      chk({nm, "_ferr"}, 32'(o.ferr), 32'(e_ferr));
      chk({nm, "_lat"},  32'(o.lat),  32'(exp_lat(id)));
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_perr(input int id, input logic [8:0] data, input logic pbit);
    int ones;
    if (pm_of(id) == 0) return 1'b0;
    ones = $countones({data, pbit});
    if (pm_of(id) == 2) return (ones % 2) != 0;
    return (ones % 2) != 1;
  endfunction

  function automatic logic model_ferr(input int id, input logic [1:0] stops);
    logic e;
    e = 1'b0;
    for (int s = 0; s < sb_of(id); s++) if (!stops[s]) e = 1'b1;
    return e;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int         id;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  // ---------------- main sequence ----------------
  initial begin
    int         b;
    int         id;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] st;

    tbl[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    tbl[1] = '{1, 9'h03C, 1'b1, 2'b11, 9'h03C, 1'b1, 1'b0};
    tbl[2] = '{1, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
    tbl[3] = '{2, 9'h055, 1'b1, 2'b01, 9'h055, 1'b0, 1'b1};
    tbl[4] = '{0, 9'h0FF, 1'b0, 2'b10, 9'h0FF, 1'b0, 1'b1};
    tbl[5] = '{1, 9'h081, 1'b0, 2'b11, 9'h081, 1'b0, 1'b0};
    tbl[6] = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0};
    tbl[7] = '{2, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
    tbl[8] = '{2, 9'h000, 1'b0, 2'b11, 9'h000, 1'b1, 1'b0};
    tbl[9] = '{1, 9'h000, 1'b1, 2'b10, 9'h000, 1'b1, 1'b1};

    rst_n = 1'b0;
    rdy   = 1'b1;
    for (int g = 0; g < 3; g++) rx_line[g] = 1'b1;
    tick(3);
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset_out%0d", g),
          32'({dout[g], vld[g], perr[g], ferr[g], ovr[g], busy[g], fst[g]}), 32'd0);
    rst_n = 1'b1;
    tick(4);
    for (int g = 0; g < 3; g++) chk($sformatf("idle_state%0d", g), 32'(fst[g]), 32'd0);

    // Table-driven frames.
    for (int k = 0; k < NV; k++) begin
      send_frame(tbl[k].id, tbl[k].data, tbl[k].pbit, tbl[k].stops, 8);
      expect_word(tbl[k].id, tbl[k].exp_data, tbl[k].exp_perr, tbl[k].exp_ferr,
                  $sformatf("vec%0d", k));
      tick(2);
      chk($sformatf("vec%0d_once", k), 32'(obs_q.size()), 32'd0);
    end

    // Short low glitch: START is entered and abandoned, no word.
    b = start_cnt[0];
    rx_line[0] = 1'b0;
    tick(5);
    rx_line[0] = 1'b1;
    tick(40);
    chk("glitch_start_seen", 32'(start_cnt[0] - b), 32'd1);
    chk("glitch_no_word", 32'(obs_q.size()), 32'd0);
    chk("glitch_idle", 32'(fst[0]), 32'd0);
    send_frame(0, 9'h081, 1'b0, 2'b11, 8);
    expect_word(0, 9'h081, 1'b0, 1'b0, "after_glitch");

    // Break: line held low delivers 0 with frame error, then no re-arm.
    b = start_cnt[0];
    rx_line[0] = 1'b0;
    tick(12 * C);
    expect_word(0, 9'h000, 1'b0, 1'b1, "break");
    chk("break_idle", 32'(fst[0]), 32'd0);
    chk("break_not_busy", 32'(busy[0]), 32'd0);
    chk("break_one_start", 32'(start_cnt[0] - b), 32'd1);
    rx_line[0] = 1'b1;
    tick(20);
    chk("break_no_more", 32'(obs_q.size()), 32'd0);

    // Overrun: back-to-back frames with the consumer stalled.
    rdy = 1'b0;
    b = ovr_cnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b11, 0);
    send_frame(0, 9'h022, 1'b0, 2'b11, 8);
    expect_word(0, 9'h011, 1'b0, 1'b0, "ovr_first");
    expect_word(0, 9'h022, 1'b0, 1'b0, "ovr_second");
    chk("ovr_pulse_count", 32'(ovr_cnt[0] - b), 32'd1);
    tick(20);
    chk("ovr_valid_held", 32'(vld[0]), 32'd1);
    chk("ovr_data_held", 32'(dout[0]), 32'h022);
    rdy = 1'b1;
    tick(2);
    chk("ovr_valid_cleared", 32'(vld[0]), 32'd0);
    chk("ovr_no_extra", 32'(obs_q.size()), 32'd0);

    // Reset during data bit 3 while a word is held.
    rdy = 1'b0;
    send_frame(0, 9'h05A, 1'b0, 2'b11, 8);
    expect_word(0, 9'h05A, 1'b0, 1'b0, "pre_reset");
    chk("pre_reset_valid", 32'(vld[0]), 32'd1);
    rx_line[0] = 1'b0;
    tick(C + 3 * C + C / 2);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("midreset_out%0d", g),
          32'({dout[g], vld[g], perr[g], ferr[g], ovr[g], busy[g], fst[g]}), 32'd0);
    rx_line[0] = 1'b1;
    tick(3);
    rst_n = 1'b1;
    rdy   = 1'b1;
    tick(40);
    chk("post_reset_no_word", 32'(obs_q.size()), 32'd0);
    chk("post_reset_idle", 32'(fst[0]), 32'd0);
    send_frame(0, 9'h0F0, 1'b0, 2'b11, 8);
    expect_word(0, 9'h0F0, 1'b0, 1'b0, "post_reset");

    // Random frames against the reference model.
    for (int r = 0; r < 30; r++) begin
      id    = $urandom_range(0, 2);
      data  = 9'($urandom) & 9'((1 << db_of(id)) - 1);
      pbit  = 1'($urandom_range(0, 1));
      st[0] = ($urandom_range(0, 7) != 0);
      st[1] = ($urandom_range(0, 7) != 0);
      send_frame(id, data, pbit, st, $urandom_range(4, 24));
      expect_word(id, data, model_perr(id, data, pbit), model_ferr(id, st),
                  $sformatf("rnd%0d", r));
      tick(2);
      chk($sformatf("rnd%0d_once", r), 32'(obs_q.size()), 32'd0);
    end

    chk("hold_stability", 32'(hold_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: configurable data width, parity mode and stop-bit count, with an internal baud counter, input synchroniser and false-start rejection. Received words are held on a valid/ready handshake, and parity, framing and overrun errors are flagged. It sits between the board RX pin and the byte consumer (FIFO or command decoder) in the UART path. It derives bit timing from `system_clk` and needs no external tick.

## Interface
- `CLKS_PER_BIT`, 868: `system_clk` cycles per bit. Must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- `system_clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `rx_data`  in  1  serial line, asynchronous, idles high
- `rx_ready`  in  1  consumer accepts the held word
- `data_out`  out  DATA_BITS  received word, LSB first on the line
- `rx_valid`  out  1  `data_out` and error flags are valid
- `parity_err`  out  1  parity mismatch for the held word; forced 0 when PARITY=0
- `frame_err`  out  1  a stop bit was sampled low for the held word
- `overrun_err`  out  1  one-cycle pulse when a word is overwritten before acceptance
- `busy`  out  1  FSM not in IDLE
- `flag_state`  out  3  current FSM state encoding, for debug

## Operation
- `rx_data` passes through a 2-flop synchroniser, reset to 1. The FSM sees only the synchronised value `rx_s`.
- Baud counter `cnt` is $clog2(CLKS_PER_BIT) bits wide. It clears on every state entry and on every sample.
- State encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. Any other encoding returns to IDLE.
- IDLE:
  - Clear `cnt` and the bit index.
  - If `rx_s`==0, go to START.
- START:
  - When `cnt`==CLKS_PER_BIT/2-1, sample `rx_s`.
  - If `rx_s`==0, go to DATA. If `rx_s`==1, treat it as a false start and return to IDLE with no output change.
- DATA:
  - When `cnt`==CLKS_PER_BIT-1, shift `rx_s` into the MSB of shift register `sr` (right shift).
  - Increment the bit index.
  - After bit DATA_BITS-1, go to PARITY if PARITY≠0, else go to STOP.
- PARITY:
  - Sample at `cnt`==CLKS_PER_BIT-1.
  - Even-mode error: XOR(data, parity bit) ≠ 0. Odd-mode error: XOR(data, parity bit) ≠ 1.
  - Go to STOP.
- STOP:
  - Sample each stop bit at `cnt`==CLKS_PER_BIT-1. Any low stop bit sets the frame error.
  - After the last stop bit, commit and go to IDLE. The FSM can detect the next start bit in the second half of the stop bit.
- Commit:
  - `data_out` <= `sr`; `parity_err` and `frame_err` take the frame's results; `rx_valid` <= 1.
  - If `rx_valid` was already 1 and `rx_ready` is 0 in the commit cycle, pulse `overrun_err` for one cycle. The new word overwrites the old one.
- Handshake:
  - `rx_valid` stays high until a cycle where `rx_valid`&`rx_ready`, then clears on the next edge.
  - If a commit and an acceptance occur in the same cycle, the commit wins: `rx_valid` stays 1 with the new data and there is no overrun.
  - `data_out` and the error flags are stable while `rx_valid`=1.
- A frame with `frame_err` is still delivered; the consumer decides whether to keep it. A break (line held low) yields data 0 with `frame_err`=1, then the FSM waits in IDLE for the line to return high before re-arming. A 1→0 edge is required to enter START again.

## Timing
- Reset values:
  - All outputs 0, `flag_state`=0.
  - Synchroniser flops 1, `sr`=0, FSM in IDLE.
- Reset mid-frame aborts immediately. No `rx_valid` follows, and reception restarts at the next falling edge after `rst_n` deasserts.
- Pin to FSM latency: 2 cycles.
- START entry to commit edge: CLKS_PER_BIT/2 + (DATA_BITS + (PARITY≠0) + STOP_BITS)·CLKS_PER_BIT cycles. `rx_valid` is high in the cycle after the commit edge.
- Glitch rejection: a low pulse shorter than CLKS_PER_BIT/2 cycles (after sync) is rejected.

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0xA5 with `rx_ready`=1:
  - `rx_valid` pulses once with `data_out`=0xA5 and no errors.
  - Timing: 16/2+9·16 = 152 cycles from START entry.
- 8E1, send 0x3C with the parity bit forced to 1 → `data_out`=0x3C, `parity_err`=1. Resend with the correct parity (0) → `parity_err`=0.
- 7O2, send 0x55 with the second stop bit low → `data_out`=0x55, `frame_err`=1, `parity_err`=0.
- Drive `rx_data` low for 5 cycles at CLKS_PER_BIT=16:
  - FSM returns to IDLE via START, with no `rx_valid`.
  - A following valid 0x81 frame is received correctly.
- `rx_ready`=0, back-to-back frames 0x11 then 0x22:
  - `overrun_err` pulses one cycle at the second commit.
  - `data_out`=0x22, `rx_valid` held until `rx_ready`=1, then clears.
- Assert `rst_n`=0 during data bit 3 of a frame:
  - All outputs go to 0 at once.
  - After release, the next frame 0xF0 is received correctly.
